sdram_wb_port: RTL and testbench

- Wishbone classic 32-bit slave that feeds the 16-bit internal request interface of the SDRAM controller; sits directly upstream of it, on the same clock.
- Writes: one 32-bit access becomes two single-halfword controller writes.
- Reads: one full controller burst fills a one-line read buffer; later reads that hit the line are answered from the buffer without touching SDRAM.

---
 rtl/sdram_wb_port.sv | 201 ++++++++++++++++++++
 tb/tb_sdram_wb_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_port.sv
// rtl/sdram_wb_port.sv - Wishbone 32-bit slave to 16-bit SDRAM request bridge with a one-line read buffer.
// Optional SDRAM_WB_PORT_WRITE_UPDATE_EN: writes hitting the buffered line merge into it instead of invalidating it.
module sdram_wb_port #(
  parameter int BURST_LENGTH = 8
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [31:0] sdram_adr_o,
  output logic [15:0] sdram_dat_o,
  output logic [1:0]  sdram_sel_o,
  output logic        sdram_acc_o,
  output logic        sdram_we_o,
  output logic        sdram_dv_o,
  input  logic        sdram_ack_i,
  input  logic        sdram_vld_i,
  input  logic [31:0] sdram_adr_i,
  input  logic [15:0] sdram_dat_i
);
  localparam int LINE_AW = (BURST_LENGTH == 8) ? 4 : 3;
  localparam int TAG_W   = 32 - LINE_AW;
  localparam int IDX_W   = LINE_AW - 1;
  localparam int KW      = LINE_AW - 2;
  localparam int CNT_W   = $clog2(BURST_LENGTH) + 1;

  typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RD_REQ, RD_FILL, ACK} state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d, we_q, we_d, dv_q, dv_d, ack_q, ack_d, valid_q, valid_d;
  logic [31:0]      adr_q, adr_d, wb_dat_q, wb_dat_d;
  logic [15:0]      dat_q, dat_d;
  logic [1:0]       sel_q, sel_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      buf_q [BURST_LENGTH];
  logic [15:0]      buf_d [BURST_LENGTH];

  logic             start, hit;
  logic [TAG_W-1:0] req_tag;
  logic [KW-1:0]    req_k;
  logic [IDX_W-1:0] beat_idx;
  logic             unused_bits;

  assign start    = wb_cyc_i & wb_stb_i;
  assign req_tag  = wb_adr_i[31:LINE_AW];
  assign req_k    = wb_adr_i[LINE_AW-1:2];
  assign hit      = valid_q && (tag_q == req_tag);
  assign beat_idx = sdram_adr_i[LINE_AW-1:1];
  assign unused_bits = ^{sdram_adr_i[31:LINE_AW], sdram_adr_i[0], wb_adr_i[1:0]};

`ifdef SDRAM_WB_PORT_WRITE_UPDATE_EN
  function automatic logic [15:0] merge_hw(input logic [15:0] old_hw, input logic [15:0] new_hw,
                                           input logic [1:0] sel);
    return {sel[1] ? new_hw[15:8] : old_hw[15:8], sel[0] ? new_hw[7:0] : old_hw[7:0]};
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    we_d     = we_q;
    dv_d     = dv_q;
    ack_d    = 1'b0;
    valid_d  = valid_q;
    adr_d    = adr_q;
    wb_dat_d = wb_dat_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    tag_d    = tag_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (wb_we_i) begin
            if (hit) begin
`ifdef SDRAM_WB_PORT_WRITE_UPDATE_EN
              buf_d[{req_k, 1'b0}] = merge_hw(buf_q[{req_k, 1'b0}], wb_dat_i[31:16], wb_sel_i[3:2]);
              buf_d[{req_k, 1'b1}] = merge_hw(buf_q[{req_k, 1'b1}], wb_dat_i[15:0], wb_sel_i[1:0]);
`else
              valid_d = 1'b0;
`endif
            end
            acc_d   = 1'b1;
            we_d    = 1'b1;
            dv_d    = 1'b1;
            adr_d   = {wb_adr_i[31:2], 2'b00};
            dat_d   = wb_dat_i[31:16];
            sel_d   = wb_sel_i[3:2];
            state_d = WR_HI;
          end else if (hit) begin
            wb_dat_d = {buf_q[{req_k, 1'b0}], buf_q[{req_k, 1'b1}]};
            ack_d    = 1'b1;
            state_d  = ACK;
          end else begin
            // The fill overwrites the line in place, so the old contents stop being trustworthy now.
            valid_d = 1'b0;
            acc_d   = 1'b1;
            we_d    = 1'b0;
            dv_d    = 1'b0;
            adr_d   = {req_tag, {LINE_AW{1'b0}}};
            k_d     = req_k;
            cnt_d   = '0;
            state_d = RD_REQ;
          end
        end
      end
      WR_HI: begin
        if (sdram_ack_i) begin
          adr_d   = adr_q + 32'd2;
          dat_d   = wb_dat_i[15:0];
          sel_d   = wb_sel_i[1:0];
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        if (sdram_ack_i) begin
          acc_d   = 1'b0;
          we_d    = 1'b0;
          dv_d    = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      RD_REQ, RD_FILL: begin
        // Beat position comes from the returned address so wrapped bursts land correctly.
        if (sdram_vld_i) begin
          buf_d[beat_idx] = sdram_dat_i;
          cnt_d = cnt_q + 1'b1;
        end
        if (state_q == RD_REQ) begin
          if (sdram_ack_i) begin
            acc_d   = 1'b0;
            state_d = RD_FILL;
          end
        end else if (cnt_d == CNT_W'(BURST_LENGTH)) begin
          tag_d    = adr_q[31:LINE_AW];
          valid_d  = 1'b1;
          wb_dat_d = {buf_d[{k_q, 1'b0}], buf_d[{k_q, 1'b1}]};
          cnt_d    = '0;
          ack_d    = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state_q  <= IDLE;
      acc_q    <= 1'b0;
      we_q     <= 1'b0;
      dv_q     <= 1'b0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      adr_q    <= '0;
      wb_dat_q <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      tag_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < BURST_LENGTH; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      we_q     <= we_d;
      dv_q     <= dv_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      adr_q    <= adr_d;
      wb_dat_q <= wb_dat_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      tag_q    <= tag_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
    end
  end

  assign wb_dat_o    = wb_dat_q;
  assign wb_ack_o    = ack_q;
  assign sdram_adr_o = adr_q;
  assign sdram_dat_o = dat_q;
  assign sdram_sel_o = sel_q;
  assign sdram_acc_o = acc_q;
  assign sdram_we_o  = we_q;
  assign sdram_dv_o  = dv_q;
endmodule

// File: tb/tb_sdram_wb_port.sv
// tb/tb_sdram_wb_port.sv - directed self-checking bench for sdram_wb_port.
module tb_sdram_wb_port;
  logic        sdram_clk = 1'b0;
  logic        sdram_rst = 1'b1;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [31:0] sdram_adr_o;
  logic [15:0] sdram_dat_o;
  logic [1:0]  sdram_sel_o;
  logic        sdram_acc_o, sdram_we_o, sdram_dv_o;
  logic        sdram_ack_i = 1'b0, sdram_vld_i = 1'b0;
  logic [31:0] sdram_adr_i = '0;
  logic [15:0] sdram_dat_i = '0;

  int checks = 0;
  int errors = 0;

  sdram_wb_port #(.BURST_LENGTH(8)) dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sdram_adr_o(sdram_adr_o), .sdram_dat_o(sdram_dat_o), .sdram_sel_o(sdram_sel_o),
    .sdram_acc_o(sdram_acc_o), .sdram_we_o(sdram_we_o), .sdram_dv_o(sdram_dv_o),
    .sdram_ack_i(sdram_ack_i), .sdram_vld_i(sdram_vld_i), .sdram_adr_i(sdram_adr_i),
    .sdram_dat_i(sdram_dat_i)
  );

  always #5 sdram_clk = ~sdram_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge sdram_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    @(negedge sdram_clk);
    chk1("wr_hi_acc", sdram_acc_o, 1'b1);
    chk1("wr_hi_we", sdram_we_o, 1'b1);
    chk1("wr_hi_dv", sdram_dv_o, 1'b1);
    chk("wr_hi_adr", sdram_adr_o, a & 32'hFFFF_FFFC);
    chk("wr_hi_dat", {16'h0, sdram_dat_o}, {16'h0, d[31:16]});
    chk("wr_hi_sel", {30'h0, sdram_sel_o}, {30'h0, s[3:2]});
    chk1("wr_hi_no_ack", wb_ack_o, 1'b0);
    @(negedge sdram_clk);
    chk("wr_hi_hold_adr", sdram_adr_o, a & 32'hFFFF_FFFC);
    chk1("wr_hold_no_ack", wb_ack_o, 1'b0);
    sdram_ack_i = 1'b1;
    @(negedge sdram_clk);
    chk1("wr_lo_acc", sdram_acc_o, 1'b1);
    chk("wr_lo_adr", sdram_adr_o, (a & 32'hFFFF_FFFC) + 32'd2);
    chk("wr_lo_dat", {16'h0, sdram_dat_o}, {16'h0, d[15:0]});
    chk("wr_lo_sel", {30'h0, sdram_sel_o}, {30'h0, s[1:0]});
    chk1("wr_lo_no_ack", wb_ack_o, 1'b0);
    @(negedge sdram_clk);
    sdram_ack_i = 1'b0;
    chk1("wr_ack", wb_ack_o, 1'b1);
    chk1("wr_done_acc", sdram_acc_o, 1'b0);
    chk1("wr_done_we", sdram_we_o, 1'b0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge sdram_clk);
    chk1("wr_single_ack", wb_ack_o, 1'b0);
  endtask

  // Delivers n beats of a line in wrapping order from index start; the first beat carries the ack.
  task automatic fill(input int n, input logic [31:0] line, input logic [15:0] base,
                      input int start, input int bubble_at);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge sdram_clk);
        chk1("fill_no_ack", wb_ack_o, 1'b0);
        if (i == 1) chk1("fill_acc_drop", sdram_acc_o, 1'b0);
      end
      if (i == bubble_at) begin
        sdram_vld_i = 1'b0; sdram_ack_i = 1'b0;
        @(negedge sdram_clk);
        chk1("fill_bubble_no_ack", wb_ack_o, 1'b0);
      end
      sdram_ack_i = (i == 0);
      sdram_vld_i = 1'b1;
      sdram_adr_i = line + 32'(2 * ((start + i) % 8));
      sdram_dat_i = base + 16'((start + i) % 8);
    end
  endtask

  task automatic rd_start(input logic [31:0] a);
    @(negedge sdram_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
    @(negedge sdram_clk);
  endtask

  task automatic rd_finish(input string tag, input logic [31:0] exp);
    @(negedge sdram_clk);
    sdram_vld_i = 1'b0; sdram_ack_i = 1'b0;
    chk1({tag, "_ack"}, wb_ack_o, 1'b1);
    chk({tag, "_dat"}, wb_dat_o, exp);
    chk1({tag, "_acc"}, sdram_acc_o, 1'b0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sdram_clk);
    chk1({tag, "_single_ack"}, wb_ack_o, 1'b0);
  endtask

  initial begin
    @(negedge sdram_clk);
    chk1("rst_ack", wb_ack_o, 1'b0);
    chk1("rst_acc", sdram_acc_o, 1'b0);
    chk1("rst_we", sdram_we_o, 1'b0);
    chk1("rst_dv", sdram_dv_o, 1'b0);
    chk("rst_adr", sdram_adr_o, 32'h0);
    chk("rst_dat_o", wb_dat_o, 32'h0);
    sdram_rst = 1'b0;

    wb_write(32'h0000_0100, 32'h1122_3344, 4'hF);
    wb_write(32'h0000_0200, 32'hAABB_CCDD, 4'hC);

    rd_start(32'h0000_0108);
    chk1("miss_acc", sdram_acc_o, 1'b1);
    chk("miss_adr", sdram_adr_o, 32'h0000_0100);
    chk1("miss_we", sdram_we_o, 1'b0);
    chk1("miss_dv", sdram_dv_o, 1'b0);
    chk1("miss_no_ack", wb_ack_o, 1'b0);
    fill(8, 32'h0000_0100, 16'hA000, 5, 4);
    rd_finish("miss108", 32'hA004_A005);

    rd_start(32'h0000_010C);
    chk1("hit_ack", wb_ack_o, 1'b1);
    chk1("hit_no_acc", sdram_acc_o, 1'b0);
    chk("hit_dat", wb_dat_o, 32'hA006_A007);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sdram_clk);
    chk1("hit_single_ack", wb_ack_o, 1'b0);

    wb_write(32'h0000_0104, 32'hDEAD_BEEF, 4'hF);
    rd_start(32'h0000_0104);
`ifdef SDRAM_WB_PORT_WRITE_UPDATE_EN
    chk1("upd_hit_ack", wb_ack_o, 1'b1);
    chk1("upd_hit_no_acc", sdram_acc_o, 1'b0);
    chk("upd_hit_dat", wb_dat_o, 32'hDEAD_BEEF);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sdram_clk);
`else
    chk1("inv_refill_acc", sdram_acc_o, 1'b1);
    chk("inv_refill_adr", sdram_adr_o, 32'h0000_0100);
    fill(8, 32'h0000_0100, 16'hB000, 0, 99);
    rd_finish("inv_refill", 32'hB002_B003);
`endif

    rd_start(32'h0000_0300);
    chk1("abort_acc", sdram_acc_o, 1'b1);
    chk("abort_adr", sdram_adr_o, 32'h0000_0300);
    fill(2, 32'h0000_0300, 16'hD000, 0, 99);
    @(negedge sdram_clk);
    sdram_ack_i = 1'b0; sdram_vld_i = 1'b1;
    sdram_adr_i = 32'h0000_0304; sdram_dat_i = 16'hD002;
    sdram_rst = 1'b1;
    #1;
    chk1("abort_rst_acc", sdram_acc_o, 1'b0);
    chk1("abort_rst_ack", wb_ack_o, 1'b0);
    chk("abort_rst_dat_o", wb_dat_o, 32'h0);
    sdram_vld_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge sdram_clk);
    @(negedge sdram_clk);
    sdram_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sdram_clk);
      chk1("abort_no_late_ack", wb_ack_o, 1'b0);
    end

    rd_start(32'h0000_0100);
    chk1("post_rst_acc", sdram_acc_o, 1'b1);
    chk("post_rst_adr", sdram_adr_o, 32'h0000_0100);
    chk1("post_rst_no_ack", wb_ack_o, 1'b0);
    fill(8, 32'h0000_0100, 16'hC000, 0, 99);
    rd_finish("post_rst", 32'hC000_C001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
